// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counting interval timer
// with borrow-out cascade, one-shot/auto-reload and expiry handshake.
module countdown_timer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] din,
    input  logic         auto,
    input  logic         enp,
    input  logic         ent,
    input  logic         ack,
    input  logic         abort,
    output logic [N-1:0] dout,
    output logic         bco,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_n;
    logic [N-1:0] rld;
    logic [N-1:0] rld_n;
    logic         tick_q;
    logic         tick_n;
    logic         done_q;
    logic         done_n;
    logic         en;
    logic         zero;

    // Qualify counting with both cascade enables and detect terminal count.
    always_comb begin
        en   = enp && ent;
        zero = (cnt == '0);
    end

    // State register; clr forces IDLE ahead of everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-datapath logic: abort > start > count/ack.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rld_n   = rld;
        tick_n  = 1'b0;
        done_n  = done_q;
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            done_n  = 1'b0;
        end else if (start) begin
            state_n = S_RUN;
            cnt_n   = din;
            rld_n   = din;
            done_n  = 1'b0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (en && !zero) begin
                        cnt_n = cnt - N'(1);
                    end else if (en && zero) begin
                        tick_n = 1'b1;
                        if (auto) begin
                            cnt_n = rld;
                        end else begin
                            state_n = S_EXPIRED;
                            cnt_n   = '0;
                            done_n  = 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    cnt_n  = '0;
                    done_n = 1'b1;
                    if (ack) begin
                        state_n = S_IDLE;
                        done_n  = 1'b0;
                    end
                end
                S_IDLE: begin
                    cnt_n = cnt;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

    // Counter, reload value and registered status flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt    <= '0;
            rld    <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            rld    <= rld_n;
            tick_q <= tick_n;
            done_q <= done_n;
        end
    end

    // Borrow-out is combinational so a cascaded stage sees it this cycle.
    always_comb begin
        dout = cnt;
        busy = (state == S_RUN);
        bco  = zero && ent && (state == S_RUN);
        tick = tick_q;
        done = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random checks of two cascaded
// countdown_timer instances against a behavioural model.
module tb_countdown_timer;

    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int EXPD = 2;

    logic       clk = 1'b0;
    logic       clr, abort, enp, ent_lo;
    logic       start_lo, auto_lo, ack_lo;
    logic       start_hi, auto_hi, ack_hi;
    logic [3:0] din_lo, din_hi;
    logic [3:0] dout_lo, dout_hi;
    logic       bco_lo, bco_hi;
    logic       busy_lo, busy_hi;
    logic       tick_lo, tick_hi;
    logic       done_lo, done_hi;

    int m_d[2];
    int m_r[2];
    int m_ph[2];
    bit m_t[2];
    bit m_dn[2];
    bit known = 0;
    int ntot = 0;
    int npass = 0;

    always #5 clk = ~clk;

    countdown_timer #(.N(4)) u_lo (
        .clk(clk), .clr(clr), .start(start_lo), .din(din_lo),
        .auto(auto_lo), .enp(enp), .ent(ent_lo), .ack(ack_lo),
        .abort(abort), .dout(dout_lo), .bco(bco_lo), .busy(busy_lo),
        .tick(tick_lo), .done(done_lo)
    );

    countdown_timer #(.N(4)) u_hi (
        .clk(clk), .clr(clr), .start(start_hi), .din(din_hi),
        .auto(auto_hi), .enp(enp), .ent(bco_lo), .ack(ack_hi),
        .abort(abort), .dout(dout_hi), .bco(bco_hi), .busy(busy_hi),
        .tick(tick_hi), .done(done_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: one edge of one timer.
    task automatic mstep(input int i, input bit c, input bit ab,
                         input bit st, input int dn, input bit au,
                         input bit ep, input bit et, input bit ak);
        m_t[i] = 0;
        if (c) begin
            m_ph[i] = IDLE; m_d[i] = 0; m_r[i] = 0; m_dn[i] = 0;
        end else if (ab) begin
            m_ph[i] = IDLE; m_d[i] = 0; m_dn[i] = 0;
        end else if (st) begin
            m_ph[i] = RUN; m_d[i] = dn; m_r[i] = dn; m_dn[i] = 0;
        end else if (m_ph[i] == RUN && ep && et) begin
            if (m_d[i] > 0) begin
                m_d[i] = m_d[i] - 1;
            end else begin
                m_t[i] = 1;
                if (au) begin
                    m_d[i] = m_r[i];
                end else begin
                    m_ph[i] = EXPD; m_dn[i] = 1;
                end
            end
        end else if (m_ph[i] == EXPD && ak) begin
            m_ph[i] = IDLE; m_dn[i] = 0;
        end
    endtask

    function automatic bit mbco(input int i, input bit et);
        return (m_ph[i] == RUN) && (m_d[i] == 0) && et;
    endfunction

    task automatic post_chk();
        bit bl;
        bl = mbco(0, ent_lo);
        chk("lo dout", dout_lo, m_d[0]);
        chk("lo busy", busy_lo, m_ph[0] == RUN);
        chk("lo tick", tick_lo, m_t[0]);
        chk("lo done", done_lo, m_dn[0]);
        chk("lo bco", bco_lo, bl);
        chk("hi dout", dout_hi, m_d[1]);
        chk("hi busy", busy_hi, m_ph[1] == RUN);
        chk("hi tick", tick_hi, m_t[1]);
        chk("hi done", done_hi, m_dn[1]);
        chk("hi bco", bco_hi, mbco(1, bl));
    endtask

    // One clock: pre-edge bco check, edge, model update, output check.
    task automatic step();
        bit bl;
        #1;
        bl = mbco(0, ent_lo);
        if (known) begin
            chk("lo bco pre", bco_lo, bl);
            chk("hi bco pre", bco_hi, mbco(1, bl));
        end
        @(posedge clk);
        mstep(0, clr, abort, start_lo, int'(din_lo), auto_lo, enp,
              ent_lo, ack_lo);
        mstep(1, clr, abort, start_hi, int'(din_hi), auto_hi, enp,
              bl, ack_hi);
        if (clr) known = 1;
        #1;
        if (known) post_chk();
        @(negedge clk);
    endtask

    task automatic quiet();
        clr = 0; abort = 0; enp = 0; ent_lo = 0;
        start_lo = 0; auto_lo = 0; ack_lo = 0; din_lo = 0;
        start_hi = 0; auto_hi = 0; ack_hi = 0; din_hi = 0;
    endtask

    task automatic go_lo(input logic [3:0] d, input logic a);
        start_lo = 1; din_lo = d; auto_lo = a;
        step();
        start_lo = 0;
    endtask

    initial begin
        int lat;
        quiet();

        // Reset with random inputs
        clr = 1;
        start_lo = 1'($urandom); din_lo = 4'($urandom);
        enp = 1'($urandom); ent_lo = 1'($urandom);
        start_hi = 1'($urandom); abort = 1'($urandom);
        step();
        step();
        quiet();
        chk("rst dout", dout_lo, 0);
        chk("rst busy", busy_lo, 0);
        chk("rst done", done_lo, 0);

        // One-shot, din=3
        enp = 1; ent_lo = 1;
        go_lo(4'd3, 1'b0);
        chk("os load", dout_lo, 3);
        repeat (3) step();
        chk("os zero", dout_lo, 0);
        chk("os bco", bco_lo, 1);
        step();
        chk("os done", done_lo, 1);
        chk("os tick", tick_lo, 1);
        step();
        chk("os tick once", tick_lo, 0);
        ack_lo = 1;
        step();
        ack_lo = 0;
        chk("os ack", done_lo, 0);

        // Auto-reload, din=2
        go_lo(4'd2, 1'b1);
        repeat (9) step();
        chk("auto busy", busy_lo, 1);

        // Enable gating, din=5
        enp = 0;
        go_lo(4'd5, 1'b0);
        enp = 1; step();
        enp = 0; step();
        enp = 1; step();
        enp = 0; step();
        enp = 1; ent_lo = 0; step();
        chk("gate hold", dout_lo, 3);
        ent_lo = 1;
        repeat (3) step();
        ent_lo = 0; step();
        chk("gate bco", bco_lo, 0);
        ent_lo = 1; step();
        step();

        // din=0: terminal count on first enabled cycle
        go_lo(4'd0, 1'b0);
        step();
        chk("d0 tick", tick_lo, 1);
        chk("d0 done", done_lo, 1);

        // din=15: 16 enabled cycles to tick
        go_lo(4'd15, 1'b0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat == 0 && tick_lo === 1'b1) lat = k;
        end
        chk("d15 period", lat, 16);

        // start on the terminal edge wins
        go_lo(4'd2, 1'b0);
        repeat (2) step();
        start_lo = 1; din_lo = 4'd7;
        step();
        start_lo = 0;
        chk("term start dout", dout_lo, 7);
        chk("term start tick", tick_lo, 0);

        // Cascade, then abort mid-count
        abort = 1; step(); abort = 0;
        start_lo = 1; din_lo = 4'h2; auto_lo = 1;
        start_hi = 1; din_hi = 4'h1; auto_hi = 0;
        step();
        start_lo = 0; start_hi = 0;
        repeat (8) step();
        chk("casc hi zero", dout_hi, 0);
        repeat (10) step();
        start_lo = 1; start_hi = 1;
        step();
        start_lo = 0; start_hi = 0;
        repeat (2) step();
        abort = 1; step(); abort = 0;
        chk("abort lo busy", busy_lo, 0);
        chk("abort hi busy", busy_hi, 0);
        chk("abort hi dout", dout_hi, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            clr = ($urandom_range(63) == 0);
            abort = ($urandom_range(31) == 0);
            start_lo = ($urandom_range(7) == 0);
            start_hi = ($urandom_range(15) == 0);
            din_lo = 4'($urandom); din_hi = 4'($urandom);
            auto_lo = 1'($urandom); auto_hi = 1'($urandom);
            ack_lo = ($urandom_range(3) == 0);
            ack_hi = ($urandom_range(3) == 0);
            enp = ($urandom_range(3) != 0);
            ent_lo = ($urandom_range(3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
